// File: rtl/score_tally.sv
// score_tally: saturating score keeper with animated display value, high score and new-high blink
// Ports: clk, reset (async, active-high); pts_valid/pts_value point award; new_game, game_over strobes;
//        score (true total), disp_score (animated, to BCD converter), high_score, new_high (blink), busy
module score_tally #(
    parameter int MAX_SCORE   = 999999,
    parameter int TICK_DIV    = 500000,
    parameter int BLINK_TICKS = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pts_valid,
    input  logic [7:0]  pts_value,
    input  logic        new_game,
    input  logic        game_over,
    output logic [19:0] score,
    output logic [19:0] disp_score,
    output logic [19:0] high_score,
    output logic        new_high,
    output logic        busy
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_TICKS) + 1;
    typedef enum logic {PLAY, OVER} state_t;
    state_t state;
    logic [TW-1:0] tick_cnt;
    logic [BW-1:0] blink_cnt;
    logic nh_flag, blink_phase, tick;
    logic [20:0] sum;
    logic [19:0] score_next, diff, step;
    always_comb begin
        tick = tick_cnt == TW'(TICK_DIV - 1);
        sum = {1'b0, score} + {13'd0, pts_value};
        score_next = !pts_valid ? score : sum > 21'(MAX_SCORE) ? 20'(MAX_SCORE) : sum[19:0];
        diff = score - disp_score;
        // big gaps close geometrically; diff>>3 never exceeds diff, so no overshoot
        step = diff >= 20'd256 ? diff >> 3 : 20'd1;
    end
    assign new_high = nh_flag & blink_phase;
    assign busy = disp_score != score;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= PLAY;
            tick_cnt <= '0;
            blink_cnt <= '0;
            nh_flag <= 1'b0;
            blink_phase <= 1'b0;
            score <= '0;
            disp_score <= '0;
            high_score <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (new_game) begin
                state <= PLAY;
                score <= '0;
                disp_score <= '0;
                nh_flag <= 1'b0;
                blink_phase <= 1'b0;
                blink_cnt <= '0;
            end else begin
                if (tick && disp_score < score)
                    disp_score <= disp_score + step;
                if (tick && nh_flag) begin
                    blink_cnt <= blink_cnt == BW'(BLINK_TICKS - 1) ? '0 : blink_cnt + BW'(1);
                    if (blink_cnt == BW'(BLINK_TICKS - 1))
                        blink_phase <= ~blink_phase;
                end
                // commit is placed after the blink update so it wins if both land on one cycle
                if (state == PLAY) begin
                    score <= score_next;
                    if (game_over) begin
                        state <= OVER;
                        if (score_next > high_score) begin
                            high_score <= score_next;
                            nh_flag <= 1'b1;
                            blink_phase <= 1'b1;
                            blink_cnt <= '0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_score_tally.sv
// tb_score_tally: scoreboard bench for score_tally (TICK_DIV=4, BLINK_TICKS=2)
module tb_score_tally;
    logic clk = 0, reset = 1, pts_valid = 0, new_game = 0, game_over = 0;
    logic [7:0] pts_value = 0;
    logic [19:0] score, disp_score, high_score;
    logic new_high, busy;
    logic [19:0] q_score[$], q_disp[$], q_high[$], q_nh[$];
    logic [19:0] ps = 0, pd = 0, ph = 0;
    logic pn = 0;
    int total = 0, bad = 0, n = 0;
    bit chk_disp = 1;

    always #5 clk = ~clk;

    score_tally #(.MAX_SCORE(999999), .TICK_DIV(4), .BLINK_TICKS(2)) dut (
        .clk(clk), .reset(reset), .pts_valid(pts_valid), .pts_value(pts_value),
        .new_game(new_game), .game_over(game_over), .score(score), .disp_score(disp_score),
        .high_score(high_score), .new_high(new_high), .busy(busy)
    );

    task automatic cmp(input string nm, input logic [19:0] act, input logic [19:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexp(input string nm, input logic [19:0] act);
        total++;
        bad++;
        $display("FAIL %s: unexpected change to %0d at %0t", nm, act, $time);
    endtask

    task automatic nx();
        @(negedge clk);
        n++;
    endtask

    task automatic award(input logic [7:0] v);
        pts_valid = 1;
        pts_value = v;
        nx();
        pts_valid = 0;
    endtask

    // monitor: every observed output change pops the next expected value
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (score !== ps) begin
                if (q_score.size() != 0) cmp("score", score, q_score.pop_front());
                else unexp("score", score);
                ps = score;
            end
            if (disp_score !== pd) begin
                if (chk_disp) begin
                    if (q_disp.size() != 0) cmp("disp_score", disp_score, q_disp.pop_front());
                    else unexp("disp_score", disp_score);
                end
                pd = disp_score;
            end
            if (high_score !== ph) begin
                if (q_high.size() != 0) cmp("high_score", high_score, q_high.pop_front());
                else unexp("high_score", high_score);
                ph = high_score;
            end
            if (new_high !== pn) begin
                if (q_nh.size() != 0) cmp("new_high", {19'd0, new_high}, q_nh.pop_front());
                else unexp("new_high", {19'd0, new_high});
                pn = new_high;
            end
        end
    end

    initial begin
        int s;
        @(negedge clk);
        cmp("rst_score", score, 0);
        cmp("rst_disp", disp_score, 0);
        cmp("rst_high", high_score, 0);
        cmp("rst_new_high", {19'd0, new_high}, 0);
        cmp("rst_busy", {19'd0, busy}, 0);

        // three back-to-back awards of 5, display walks up by 1 per tick
        reset = 0;
        n = 1;
        q_score.push_back(5); q_score.push_back(10); q_score.push_back(15);
        for (int v = 1; v <= 15; v++) q_disp.push_back(20'(v));
        award(5); award(5); award(5);
        while (n < 60) nx();
        cmp("t1_disp_before", disp_score, 14);
        cmp("t1_busy_before", {19'd0, busy}, 1);
        nx();
        cmp("t1_disp_done", disp_score, 15);
        cmp("t1_busy_done", {19'd0, busy}, 0);

        // 200 + 200: geometric steps 50,93,131,164 then unit steps to 400
        q_score.push_back(0); q_disp.push_back(0);
        reset = 1;
        nx();
        reset = 0;
        n = 1;
        q_score.push_back(200); q_score.push_back(400);
        q_disp.push_back(50); q_disp.push_back(93); q_disp.push_back(131); q_disp.push_back(164);
        for (int v = 165; v <= 400; v++) q_disp.push_back(20'(v));
        award(200); award(200);
        while (n < 1000) nx();
        cmp("t2_disp_done", disp_score, 400);
        cmp("t2_busy_done", {19'd0, busy}, 0);

        // saturation: climb to 999990, then +255 clips to 999999, +1 holds
        chk_disp = 0;
        q_score.push_back(0);
        new_game = 1;
        nx();
        new_game = 0;
        s = 0;
        for (int i = 0; i < 3921; i++) begin
            s += 255;
            q_score.push_back(20'(s));
            award(255);
        end
        q_score.push_back(999990);
        award(135);
        q_score.push_back(999999);
        award(255);
        award(1);
        nx();
        cmp("t3_sat_score", score, 999999);

        // score 300, game over, blink, ignored awards in OVER, new_game
        q_score.push_back(0);
        reset = 1;
        nx();
        chk_disp = 1;
        reset = 0;
        n = 1;
        q_score.push_back(255); q_score.push_back(300); q_score.push_back(0);
        q_high.push_back(300);
        q_nh.push_back(1); q_nh.push_back(0); q_nh.push_back(1);
        q_nh.push_back(0); q_nh.push_back(1); q_nh.push_back(0);
        q_disp.push_back(37); q_disp.push_back(69);
        for (int v = 70; v <= 75; v++) q_disp.push_back(20'(v));
        q_disp.push_back(0);
        award(255); award(45);
        game_over = 1;
        nx();
        game_over = 0;
        award(50);
        game_over = 1;
        nx();
        game_over = 0;
        cmp("t4_over_score", score, 300);
        cmp("t4_high", high_score, 300);
        while (n < 34) nx();
        new_game = 1;
        nx();
        new_game = 0;
        cmp("t4_ng_score", score, 0);
        cmp("t4_ng_disp", disp_score, 0);
        cmp("t4_ng_new_high", {19'd0, new_high}, 0);
        cmp("t4_ng_high", high_score, 300);

        // new_game beats pts_valid; award and game_over on the same cycle
        new_game = 1;
        pts_valid = 1;
        pts_value = 9;
        nx();
        new_game = 0;
        pts_valid = 0;
        cmp("t5_ng_prio", score, 0);
        q_score.push_back(200); q_score.push_back(295); q_score.push_back(305);
        q_high.push_back(305);
        q_nh.push_back(1);
        q_disp.push_back(38);
        award(200); award(95);
        game_over = 1;
        pts_valid = 1;
        pts_value = 10;
        nx();
        game_over = 0;
        pts_valid = 0;
        while (n < 42) nx();
        cmp("t5_busy", {19'd0, busy}, 1);
        cmp("t5_high", high_score, 305);
        cmp("t5_new_high", {19'd0, new_high}, 1);
        cmp("t5_disp", disp_score, 38);

        // asynchronous reset mid-animation and mid-blink
        q_score.push_back(0); q_disp.push_back(0); q_high.push_back(0); q_nh.push_back(0);
        reset = 1;
        #1;
        cmp("t6_score", score, 0);
        cmp("t6_disp", disp_score, 0);
        cmp("t6_high", high_score, 0);
        cmp("t6_new_high", {19'd0, new_high}, 0);
        cmp("t6_busy", {19'd0, busy}, 0);
        nx();
        reset = 0;
        n = 1;
        q_score.push_back(7);
        for (int v = 1; v <= 7; v++) q_disp.push_back(20'(v));
        award(7);
        while (n < 40) nx();
        cmp("t6_resume_disp", disp_score, 7);
        cmp("t6_resume_busy", {19'd0, busy}, 0);

        cmp("q_score_left", 20'(q_score.size()), 0);
        cmp("q_disp_left", 20'(q_disp.size()), 0);
        cmp("q_high_left", 20'(q_high.size()), 0);
        cmp("q_nh_left", 20'(q_nh.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
